// File: rtl/mem_arbiter_pkg.sv
// Shared sizes, owner tags and helpers for the frame-buffer SRAM arbiter.
// The top module re-exposes FRAME_WORDS and STARVE_LIMIT as overridable parameters.
package mem_arbiter_pkg;

  localparam int LOG_MEM      = 36;
  localparam int LOG_ADDR     = 19;
  localparam int FRAME_WORDS  = 153600;
  localparam int MEM_LATENCY  = 2;
  localparam int STARVE_LIMIT = 15;

  typedef enum logic [1:0] {
    OWN_VGA  = 2'd0,
    OWN_NTSC = 2'd1,
    OWN_PROC = 2'd2
  } owner_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_VGA  = 2'd1,
    GNT_NTSC = 2'd2,
    GNT_PROC = 2'd3
  } grant_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
  } rd_tag_t;

  // Frame pointer advance: the last word of a frame wraps back to word 0.
  function automatic int wrap_inc(input int ptr, input int words);
    return (ptr == words - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_read_return_pipe.sv
// Tags every issued SRAM read with its owner and delays the tag by the memory
// latency, so the tag leaving the last stage marks the cycle its data is valid.
module read_return_pipe
  import mem_arbiter_pkg::*;
#(
  parameter int DEPTH = MEM_LATENCY
) (
  input  logic   i_clock,
  input  logic   i_reset_b,
  input  logic   i_push,
  input  owner_t i_owner,
  output logic   o_cap_vga,
  output logic   o_cap_proc,
  output logic   o_proc_inflight
);

  rd_tag_t          r_tag [DEPTH];
  logic [DEPTH-1:0] w_is_proc;

  always_ff @(posedge i_clock) begin
    if (!i_reset_b) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_tag[i] <= '0;
      end
    end else begin
      r_tag[0] <= '{valid: i_push, owner: i_owner};
      for (int i = 1; i < DEPTH; i++) begin
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      assign w_is_proc[gi] = r_tag[gi].valid && (r_tag[gi].owner == OWN_PROC);
    end
  endgenerate

  assign o_cap_vga       = r_tag[DEPTH-1].valid && (r_tag[DEPTH-1].owner == OWN_VGA);
  assign o_cap_proc      = w_is_proc[DEPTH-1];
  assign o_proc_inflight = |w_is_proc;

endmodule

// File: rtl/mem_arbiter.sv
// Single-port frame-buffer SRAM arbiter: VGA reads, NTSC capture writes and
// processing-engine accesses, with double-buffered display/capture banks.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int P_FRAME_WORDS  = FRAME_WORDS,
  parameter int P_STARVE_LIMIT = STARVE_LIMIT
) (
  input  logic                clock,
  input  logic                reset_b,
  input  logic                frame_flag,
  input  logic                vga_flag,
  output logic [LOG_MEM-1:0]  vga_pixel,
  output logic                done_vga,
  input  logic                ntsc_flag,
  input  logic [LOG_MEM-1:0]  ntsc_pixel,
  input  logic                ntsc_frame_end,
  output logic                done_ntsc,
  input  logic                proc_flag,
  input  logic                proc_we,
  input  logic [LOG_ADDR-1:0] proc_addr,
  input  logic [LOG_MEM-1:0]  proc_wdata,
  output logic [LOG_MEM-1:0]  proc_rdata,
  output logic                done_proc,
  output logic                display_bank,
  output logic [LOG_ADDR-1:0] mem_addr,
  output logic                mem_we_b,
  output logic [LOG_MEM-1:0]  mem_wdata,
  input  logic [LOG_MEM-1:0]  mem_rdata
);

  localparam int PTR_W    = LOG_ADDR - 1;
  localparam int STARVE_W = $clog2(P_STARVE_LIMIT + 1);

  logic [PTR_W-1:0]    r_vga_ptr;
  logic [PTR_W-1:0]    r_ntsc_ptr;
  logic                r_swap_pending;
  logic [STARVE_W-1:0] r_starve_cnt;

  logic [PTR_W-1:0]    w_vga_ptr_inc;
  logic [PTR_W-1:0]    w_ntsc_ptr_inc;
  grant_t              w_grant;
  logic                w_proc_req;
  logic                w_promote;
  logic                w_swap_now;
  logic                w_push;
  owner_t              w_push_owner;
  logic                w_cap_vga;
  logic                w_cap_proc;
  logic                w_proc_inflight;

  assign w_vga_ptr_inc  = PTR_W'(wrap_inc(int'(r_vga_ptr), P_FRAME_WORDS));
  assign w_ntsc_ptr_inc = PTR_W'(wrap_inc(int'(r_ntsc_ptr), P_FRAME_WORDS));

  // Only one proc read may be outstanding, so its return slot is unambiguous.
  assign w_proc_req = proc_flag && !w_proc_inflight;
  assign w_promote  = (r_starve_cnt >= STARVE_W'(P_STARVE_LIMIT));

  always_comb begin
    w_grant = GNT_NONE;
    if (vga_flag) begin
      w_grant = GNT_VGA;
    end else if (w_proc_req && w_promote) begin
      w_grant = GNT_PROC;
    end else if (ntsc_flag) begin
      w_grant = GNT_NTSC;
    end else if (w_proc_req) begin
      w_grant = GNT_PROC;
    end
  end

  // A frame end arriving together with the frame start still swaps immediately.
  assign w_swap_now   = frame_flag && (r_swap_pending || ntsc_frame_end);
  assign w_push       = (w_grant == GNT_VGA) || ((w_grant == GNT_PROC) && !proc_we);
  assign w_push_owner = (w_grant == GNT_VGA) ? OWN_VGA : OWN_PROC;

  read_return_pipe #(
    .DEPTH(MEM_LATENCY)
  ) u_read_return_pipe (
    .i_clock        (clock),
    .i_reset_b      (reset_b),
    .i_push         (w_push),
    .i_owner        (w_push_owner),
    .o_cap_vga      (w_cap_vga),
    .o_cap_proc     (w_cap_proc),
    .o_proc_inflight(w_proc_inflight)
  );

  always_ff @(posedge clock) begin
    if (!reset_b) begin
      mem_addr  <= '0;
      mem_we_b  <= 1'b1;
      mem_wdata <= '0;
      done_ntsc <= 1'b0;
    end else begin
      mem_we_b  <= 1'b1;
      done_ntsc <= 1'b0;
      case (w_grant)
        GNT_VGA: begin
          mem_addr <= {display_bank, r_vga_ptr};
        end
        GNT_NTSC: begin
          mem_addr  <= {~display_bank, r_ntsc_ptr};
          mem_we_b  <= 1'b0;
          mem_wdata <= ntsc_pixel;
          done_ntsc <= 1'b1;
        end
        GNT_PROC: begin
          mem_addr <= proc_addr;
          mem_we_b <= ~proc_we;
          if (proc_we) begin
            mem_wdata <= proc_wdata;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_b) begin
      vga_pixel  <= '0;
      proc_rdata <= '0;
      done_vga   <= 1'b0;
      done_proc  <= 1'b0;
    end else begin
      done_vga  <= w_cap_vga;
      done_proc <= w_cap_proc || ((w_grant == GNT_PROC) && proc_we);
      if (w_cap_vga) begin
        vga_pixel <= mem_rdata;
      end
      if (w_cap_proc) begin
        proc_rdata <= mem_rdata;
      end
    end
  end

  // Pointer resets win over the increment; the granted access already used the old value.
  always_ff @(posedge clock) begin
    if (!reset_b) begin
      r_vga_ptr      <= '0;
      r_ntsc_ptr     <= '0;
      r_swap_pending <= 1'b0;
      display_bank   <= 1'b0;
    end else begin
      if (frame_flag) begin
        r_vga_ptr <= '0;
      end else if (w_grant == GNT_VGA) begin
        r_vga_ptr <= w_vga_ptr_inc;
      end

      if (ntsc_frame_end) begin
        r_ntsc_ptr <= '0;
      end else if (w_grant == GNT_NTSC) begin
        r_ntsc_ptr <= w_ntsc_ptr_inc;
      end

      if (w_swap_now) begin
        display_bank   <= ~display_bank;
        r_swap_pending <= 1'b0;
      end else if (ntsc_frame_end) begin
        r_swap_pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_b) begin
      r_starve_cnt <= '0;
    end else if (!proc_flag || (w_grant == GNT_PROC)) begin
      r_starve_cnt <= '0;
    end else if (!w_promote) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; the SRAM model returns the read address as data.
// A short frame length keeps the pointer-wrap scenario within a small cycle budget.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int TB_FRAME = 8;

  logic                clock = 1'b0;
  logic                reset_b;
  logic                frame_flag;
  logic                vga_flag;
  logic [LOG_MEM-1:0]  vga_pixel;
  logic                done_vga;
  logic                ntsc_flag;
  logic [LOG_MEM-1:0]  ntsc_pixel;
  logic                ntsc_frame_end;
  logic                done_ntsc;
  logic                proc_flag;
  logic                proc_we;
  logic [LOG_ADDR-1:0] proc_addr;
  logic [LOG_MEM-1:0]  proc_wdata;
  logic [LOG_MEM-1:0]  proc_rdata;
  logic                done_proc;
  logic                display_bank;
  logic [LOG_ADDR-1:0] mem_addr;
  logic                mem_we_b;
  logic [LOG_MEM-1:0]  mem_wdata;
  logic [LOG_MEM-1:0]  mem_rdata;

  logic [LOG_ADDR-1:0] r_mem_q;
  int n_vec = 0;
  int n_err = 0;
  int ntsc_ptr_exp = 0;

  always #5 clock = ~clock;

  // Address registered once by the SRAM, data valid the following cycle.
  always_ff @(posedge clock) r_mem_q <= mem_addr;
  assign mem_rdata = LOG_MEM'(r_mem_q);

  mem_arbiter #(
    .P_FRAME_WORDS (TB_FRAME),
    .P_STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clock         (clock),
    .reset_b       (reset_b),
    .frame_flag    (frame_flag),
    .vga_flag      (vga_flag),
    .vga_pixel     (vga_pixel),
    .done_vga      (done_vga),
    .ntsc_flag     (ntsc_flag),
    .ntsc_pixel    (ntsc_pixel),
    .ntsc_frame_end(ntsc_frame_end),
    .done_ntsc     (done_ntsc),
    .proc_flag     (proc_flag),
    .proc_we       (proc_we),
    .proc_addr     (proc_addr),
    .proc_wdata    (proc_wdata),
    .proc_rdata    (proc_rdata),
    .done_proc     (done_proc),
    .display_bank  (display_bank),
    .mem_addr      (mem_addr),
    .mem_we_b      (mem_we_b),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [LOG_ADDR-1:0] mk_addr(input logic bank, input int ptr);
    return {bank, (LOG_ADDR-1)'(ptr)};
  endfunction

  task automatic vga_read(input logic [LOG_ADDR-1:0] addr);
    vga_flag = 1'b1;
    tick();
    vga_flag = 1'b0;
    chk("vga_addr", mem_addr, addr);
    chk("vga_we_b", mem_we_b, 1);
    tick();
    chk("vga_done_early", done_vga, 0);
    tick();
    chk("vga_done", done_vga, 1);
    chk("vga_pixel", vga_pixel, addr);
    $display("vga read   addr=%05h pixel=%09h", addr, vga_pixel);
  endtask

  task automatic ntsc_write(input logic [LOG_ADDR-1:0] addr, input logic [LOG_MEM-1:0] data);
    ntsc_pixel = data;
    ntsc_flag  = 1'b1;
    tick();
    ntsc_flag = 1'b0;
    chk("ntsc_addr", mem_addr, addr);
    chk("ntsc_we_b", mem_we_b, 0);
    chk("ntsc_wdata", mem_wdata, data);
    chk("ntsc_done", done_ntsc, 1);
    tick();
    chk("ntsc_done_clear", done_ntsc, 0);
    $display("ntsc write addr=%05h data=%09h", addr, data);
  endtask

  initial begin
    reset_b = 1'b0; frame_flag = 1'b0; vga_flag = 1'b0;
    ntsc_flag = 1'b0; ntsc_pixel = '0; ntsc_frame_end = 1'b0;
    proc_flag = 1'b0; proc_we = 1'b0; proc_addr = '0; proc_wdata = '0;

    // Reset state
    tick(); tick();
    chk("rst_done_vga", done_vga, 0);
    chk("rst_done_ntsc", done_ntsc, 0);
    chk("rst_done_proc", done_proc, 0);
    chk("rst_we_b", mem_we_b, 1);
    chk("rst_addr", mem_addr, 0);
    chk("rst_vga_pixel", vga_pixel, 0);
    chk("rst_proc_rdata", proc_rdata, 0);
    chk("rst_bank", display_bank, 0);
    reset_b = 1'b1;
    tick();

    // Basic VGA reads
    vga_read(mk_addr(0, 0));
    vga_read(mk_addr(0, 1));

    // VGA and NTSC in the same cycle: VGA first, NTSC one cycle later
    ntsc_pixel = 36'h9_ABCD_1234;
    vga_flag = 1'b1; ntsc_flag = 1'b1;
    tick();
    vga_flag = 1'b0;
    chk("pri_vga_addr", mem_addr, mk_addr(0, 2));
    chk("pri_vga_we_b", mem_we_b, 1);
    chk("pri_ntsc_wait", done_ntsc, 0);
    tick();
    ntsc_flag = 1'b0;
    chk("pri_ntsc_addr", mem_addr, mk_addr(1, 0));
    chk("pri_ntsc_we_b", mem_we_b, 0);
    chk("pri_ntsc_wdata", mem_wdata, 36'h9_ABCD_1234);
    chk("pri_ntsc_done", done_ntsc, 1);
    tick();
    chk("pri_vga_done", done_vga, 1);
    chk("pri_vga_pixel", vga_pixel, mk_addr(0, 2));
    chk("pri_ntsc_done_clr", done_ntsc, 0);
    $display("priority   vga then ntsc");
    ntsc_ptr_exp = 1;
    tick();

    // Proc starvation under continuous NTSC traffic
    ntsc_pixel = 36'h1_0000_0001;
    proc_flag = 1'b1; proc_we = 1'b1; proc_addr = 19'h12345; proc_wdata = 36'h5_5555_AAAA;
    ntsc_flag = 1'b1;
    for (int k = 1; k <= STARVE_LIMIT; k++) begin
      tick();
      chk("starve_ntsc_addr", mem_addr, mk_addr(1, ntsc_ptr_exp));
      chk("starve_no_proc", done_proc, 0);
      ntsc_ptr_exp = (ntsc_ptr_exp + 1) % TB_FRAME;
    end
    tick();
    proc_flag = 1'b0;
    chk("promo_addr", mem_addr, 19'h12345);
    chk("promo_we_b", mem_we_b, 0);
    chk("promo_wdata", mem_wdata, 36'h5_5555_AAAA);
    chk("promo_done", done_proc, 1);
    chk("promo_no_ntsc", done_ntsc, 0);
    $display("proc write promoted after %0d cycles", STARVE_LIMIT + 1);
    tick();
    chk("resume_ntsc_addr", mem_addr, mk_addr(1, ntsc_ptr_exp));
    chk("resume_ntsc_done", done_ntsc, 1);
    ntsc_ptr_exp = (ntsc_ptr_exp + 1) % TB_FRAME;
    proc_flag = 1'b1;
    tick();
    // Counter was cleared, so a fresh proc request does not outrank NTSC
    chk("cnt_clear_ntsc_addr", mem_addr, mk_addr(1, ntsc_ptr_exp));
    chk("cnt_clear_no_proc", done_proc, 0);
    ntsc_ptr_exp = (ntsc_ptr_exp + 1) % TB_FRAME;
    proc_flag = 1'b0; ntsc_flag = 1'b0;
    tick(); tick();

    // Bank swap: frame end, then frame start 100 cycles later
    ntsc_frame_end = 1'b1;
    tick();
    ntsc_frame_end = 1'b0;
    repeat (99) tick();
    chk("swap_bank_before", display_bank, 0);
    frame_flag = 1'b1;
    tick();
    frame_flag = 1'b0;
    chk("swap_bank_after", display_bank, 1);
    $display("bank swap  display_bank=%0d", display_bank);
    vga_read(mk_addr(1, 0));
    ntsc_write(mk_addr(0, 0), 36'h3_3333_3333);

    // Frame start without a pending swap, then full-frame wrap
    frame_flag = 1'b1;
    tick();
    frame_flag = 1'b0;
    chk("noswap_bank", display_bank, 1);
    for (int i = 0; i < TB_FRAME; i++) vga_read(mk_addr(1, i));
    vga_read(mk_addr(1, 0));

    // Grant and pointer reset in the same cycle: old pointer used, then 0
    vga_flag = 1'b1; frame_flag = 1'b1;
    tick();
    vga_flag = 1'b0; frame_flag = 1'b0;
    chk("ptr_rst_grant_addr", mem_addr, mk_addr(1, 1));
    tick(); tick();
    chk("ptr_rst_grant_pixel", vga_pixel, mk_addr(1, 1));
    vga_read(mk_addr(1, 0));

    // Frame end and frame start together: swap immediately
    ntsc_frame_end = 1'b1; frame_flag = 1'b1;
    tick();
    ntsc_frame_end = 1'b0; frame_flag = 1'b0;
    chk("same_cycle_swap_bank", display_bank, 0);
    ntsc_write(mk_addr(1, 0), 36'h4_4444_4444);
    vga_read(mk_addr(0, 0));

    // Swap back to bank 1 so reset of display_bank is observable later
    ntsc_frame_end = 1'b1;
    tick();
    ntsc_frame_end = 1'b0; frame_flag = 1'b1;
    tick();
    frame_flag = 1'b0;
    chk("reswap_bank", display_bank, 1);
    vga_read(mk_addr(1, 0));

    // Proc read, held request must not re-grant while in flight
    proc_flag = 1'b1; proc_we = 1'b0; proc_addr = 19'h2AAAA;
    tick();
    chk("proc_rd_addr", mem_addr, 19'h2AAAA);
    chk("proc_rd_we_b", mem_we_b, 1);
    chk("proc_rd_done_early", done_proc, 0);
    tick();
    chk("proc_rd_done_early2", done_proc, 0);
    tick();
    proc_flag = 1'b0;
    chk("proc_rd_done", done_proc, 1);
    chk("proc_rd_data", proc_rdata, 19'h2AAAA);
    $display("proc read  addr=%05h data=%09h", proc_addr, proc_rdata);
    tick();
    chk("proc_rd_single_a", done_proc, 0);
    tick();
    chk("proc_rd_single_b", done_proc, 0);

    // Proc read aborted by reset one cycle after issue
    proc_flag = 1'b1; proc_we = 1'b0; proc_addr = 19'h01234;
    tick();
    chk("abort_rd_addr", mem_addr, 19'h01234);
    reset_b = 1'b0; proc_flag = 1'b0;
    tick();
    reset_b = 1'b1;
    chk("abort_addr", mem_addr, 0);
    chk("abort_we_b", mem_we_b, 1);
    chk("abort_bank", display_bank, 0);
    chk("abort_vga_pixel", vga_pixel, 0);
    chk("abort_proc_rdata", proc_rdata, 0);
    chk("abort_done_vga", done_vga, 0);
    chk("abort_done_ntsc", done_ntsc, 0);
    chk("abort_done_proc", done_proc, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("abort_no_done_proc", done_proc, 0);
    end
    $display("reset abort of proc read");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
